// File: rtl/ym_slot_sequencer.sv
// Operator-slot sequencer for the FM core: walks NUM_CH channels x 4 operators
// (op4, op1, op3, op2) per sample and decodes slot strobes, routing flags and DAC timing.
// Optional build macro YM_SEQ_ALG_LATCH_EN latches the algorithm number once per sample.
module ym_slot_sequencer #(
  parameter int NUM_CH        = 6,
  parameter int CH3_IDX       = 2,
  parameter int DAC_PERIOD    = 4,
  parameter int DAC_CH6_START = 4,
  parameter int SCNT_W        = 8
) (
  input  logic                           MCLK,
  input  logic                           reset_n,
  input  logic                           clk_en,
  input  logic                           fsm_reset,
  input  logic [2:0]                     connect,
  output logic [$clog2(4*NUM_CH)-1:0]    slot,
  output logic [$clog2(NUM_CH)-1:0]      ch_idx,
  output logic [1:0]                     op_grp,
  output logic                           fsm_sel0_o,
  output logic                           fsm_sel1_o,
  output logic                           fsm_sel2_o,
  output logic                           fsm_sel_last_o,
  output logic                           fsm_op1_sel_o,
  output logic                           fsm_op2_sel_o,
  output logic                           fsm_ch3_sel_o,
  output logic                           fsm_timer_ed_o,
  output logic                           alg_fb_sel_o,
  output logic                           alg_op2_o,
  output logic                           alg_cur1_o,
  output logic                           alg_cur2_o,
  output logic                           alg_op1_0_o,
  output logic                           alg_out_o,
  output logic                           fsm_dac_load,
  output logic                           fsm_dac_out_sel,
  output logic                           fsm_dac_ch6,
  output logic [SCNT_W-1:0]              sample_cnt,
  output logic                           sample_tick
);

  localparam int SLOTS  = 4 * NUM_CH;
  localparam int CH_W   = $clog2(NUM_CH);

  int   slot_i;
  logic timer_q;
  logic fb_q;

  assign slot_i = int'(slot);

  // Channel and operator group are pure decodes of the slot number.
  assign ch_idx = CH_W'(slot_i % NUM_CH);
  assign op_grp = 2'(slot_i / NUM_CH);

  assign fsm_sel0_o     = (slot_i == 0);
  assign fsm_sel1_o     = (slot_i == 1);
  assign fsm_sel2_o     = (slot_i == 2);
  assign fsm_sel_last_o = (slot_i == SLOTS - 1);
  assign fsm_op1_sel_o  = (op_grp == 2'd1);
  assign fsm_op2_sel_o  = (op_grp == 2'd3);
  assign fsm_ch3_sel_o  = (slot_i % NUM_CH == CH3_IDX);
  assign sample_tick    = fsm_sel0_o;

  assign fsm_dac_load    = (slot_i % DAC_PERIOD == 0);
  assign fsm_dac_out_sel = (slot_i >= SLOTS / 2);
  assign fsm_dac_ch6     = (slot_i >= DAC_CH6_START) && (slot_i < DAC_CH6_START + DAC_PERIOD);

  // The delayed copies make timer_ed a slot-3 pulse and drop fb_sel for the
  // slot after each op2 slot, which wraps into slot 0 of the next sample.
  assign fsm_timer_ed_o = timer_q & ~fsm_sel2_o;
  assign alg_fb_sel_o   = ~fb_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      slot       <= '0;
      timer_q    <= 1'b0;
      fb_q       <= 1'b0;
      sample_cnt <= '0;
    end else if (clk_en) begin
      slot    <= (fsm_reset || fsm_sel_last_o) ? '0 : slot + 1'b1;
      timer_q <= fsm_sel2_o;
      fb_q    <= fsm_op2_sel_o;
      if (fsm_sel_last_o && !fsm_reset)
        sample_cnt <= sample_cnt + 1'b1;
    end
  end

  logic [2:0] alg;
  logic [7:0] alg_sel;

`ifdef YM_SEQ_ALG_LATCH_EN
  logic [2:0] alg_q;

  // A mid-sample algorithm change is deferred to the next sample boundary.
  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n)
      alg_q <= 3'd0;
    else if (clk_en && (fsm_reset || fsm_sel_last_o))
      alg_q <= connect;
  end

  assign alg = alg_q;
`else
  assign alg = connect;
`endif

  assign alg_sel = 8'd1 << alg;

  logic op4, op1, op3, op2;
  assign op4 = (op_grp == 2'd0);
  assign op1 = (op_grp == 2'd1);
  assign op3 = (op_grp == 2'd2);
  assign op2 = (op_grp == 2'd3);

  assign alg_op2_o   = (op4 & (alg_sel[0] | alg_sel[1] | alg_sel[2]))
                     | (op3 & alg_sel[3]);
  assign alg_cur1_o  = op3 & alg_sel[2];
  assign alg_cur2_o  = (op1 & (alg_sel[0] | alg_sel[3] | alg_sel[4] | alg_sel[5] | alg_sel[6]))
                     | (op3 & (alg_sel[0] | alg_sel[1] | alg_sel[3] | alg_sel[4]));
  assign alg_op1_0_o = (op4 & (alg_sel[1] | alg_sel[5]))
                     | (op3 & (alg_sel[2] | alg_sel[5]))
                     | op2;
  assign alg_out_o   = (op1 & alg_sel[7])
                     | (op3 & (alg_sel[5] | alg_sel[6] | alg_sel[7]))
                     | (op2 & (alg_sel[4] | alg_sel[5] | alg_sel[6] | alg_sel[7]))
                     | op4;

endmodule

// File: tb/tb_ym_slot_sequencer.sv
// Directed self-checking bench for ym_slot_sequencer: a NUM_CH=6 instance for
// sequencing/reset/algorithm behaviour and a NUM_CH=8 instance for slot decodes.
module tb_ym_slot_sequencer;

  logic       MCLK = 1'b0;
  logic       reset_n, clk_en, fsm_reset;
  logic [2:0] connect;
  logic       rst8_n, en8, frst8;
  logic [2:0] conn8;

  // NUM_CH = 6 instance
  logic [4:0] slot;
  logic [2:0] ch_idx;
  logic [1:0] op_grp;
  logic sel0, sel1, sel2, sel_last, op1_sel, op2_sel, ch3_sel, timer_ed;
  logic fb_sel, a_op2, a_cur1, a_cur2, a_op1_0, a_out, dac_load, dac_out_sel, dac_ch6;
  logic [7:0] sample_cnt;
  logic sample_tick;

  // NUM_CH = 8 instance
  logic [4:0] slot8;
  logic [2:0] ch_idx8;
  logic [1:0] op_grp8;
  logic s0_8, s1_8, s2_8, sl_8, op1_8, op2_8, ch3_8, ted_8;
  logic fb_8, aop2_8, acur1_8, acur2_8, aop10_8, aout_8, dl_8, dos_8, dch6_8;
  logic [7:0] cnt8;
  logic tick8;

  int tests = 0;
  int failures = 0;
  int exp_slot;

`ifdef YM_SEQ_ALG_LATCH_EN
  localparam bit LATCHED = 1'b1;
`else
  localparam bit LATCHED = 1'b0;
`endif

  always #5 MCLK = ~MCLK;

  ym_slot_sequencer #(.NUM_CH(6)) dut (
    .MCLK(MCLK), .reset_n(reset_n), .clk_en(clk_en), .fsm_reset(fsm_reset), .connect(connect),
    .slot(slot), .ch_idx(ch_idx), .op_grp(op_grp),
    .fsm_sel0_o(sel0), .fsm_sel1_o(sel1), .fsm_sel2_o(sel2), .fsm_sel_last_o(sel_last),
    .fsm_op1_sel_o(op1_sel), .fsm_op2_sel_o(op2_sel), .fsm_ch3_sel_o(ch3_sel),
    .fsm_timer_ed_o(timer_ed), .alg_fb_sel_o(fb_sel), .alg_op2_o(a_op2), .alg_cur1_o(a_cur1),
    .alg_cur2_o(a_cur2), .alg_op1_0_o(a_op1_0), .alg_out_o(a_out),
    .fsm_dac_load(dac_load), .fsm_dac_out_sel(dac_out_sel), .fsm_dac_ch6(dac_ch6),
    .sample_cnt(sample_cnt), .sample_tick(sample_tick)
  );

  ym_slot_sequencer #(.NUM_CH(8)) dut8 (
    .MCLK(MCLK), .reset_n(rst8_n), .clk_en(en8), .fsm_reset(frst8), .connect(conn8),
    .slot(slot8), .ch_idx(ch_idx8), .op_grp(op_grp8),
    .fsm_sel0_o(s0_8), .fsm_sel1_o(s1_8), .fsm_sel2_o(s2_8), .fsm_sel_last_o(sl_8),
    .fsm_op1_sel_o(op1_8), .fsm_op2_sel_o(op2_8), .fsm_ch3_sel_o(ch3_8),
    .fsm_timer_ed_o(ted_8), .alg_fb_sel_o(fb_8), .alg_op2_o(aop2_8), .alg_cur1_o(acur1_8),
    .alg_cur2_o(acur2_8), .alg_op1_0_o(aop10_8), .alg_out_o(aout_8),
    .fsm_dac_load(dl_8), .fsm_dac_out_sel(dos_8), .fsm_dac_ch6(dch6_8),
    .sample_cnt(cnt8), .sample_tick(tick8)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; fsm_reset = 1'b0; connect = 3'd7;
    rst8_n  = 1'b0; en8    = 1'b0; frst8     = 1'b0; conn8   = 3'd0;
    step(2);

    // Reset state
    check("rst_slot", slot, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_fb_sel", fb_sel, 1);
    check("rst_timer_ed", timer_ed, 0);
    check("rst_tick", sample_tick, 1);

    reset_n = 1'b1; rst8_n = 1'b1; clk_en = 1'b1;

    // 30 enabled cycles: slot 0..23 then 0..5
    for (int i = 1; i <= 30; i++) begin
      int s, p;
      step();
      s = i % 24;
      p = (i - 1) % 24;
      check("seq_slot", slot, s);
      check("seq_ch_idx", ch_idx, s % 6);
      check("seq_op_grp", op_grp, s / 6);
      check("seq_sel_last", sel_last, (s == 23));
      check("seq_timer_ed", timer_ed, (s == 3));
      check("seq_cnt", sample_cnt, (i >= 24) ? 1 : 0);
      check("seq_fb_sel", fb_sel, !(p >= 18));
    end

    // fsm_reset mid-sample: back to 0, count kept (also latches connect=7)
    fsm_reset = 1'b1; step(); fsm_reset = 1'b0;
    check("frst_slot", slot, 0);
    check("frst_cnt", sample_cnt, 1);

    // connect = 7 sweep over one sample
    for (int s = 0; s < 24; s++) begin
      check("a7_out", a_out, 1);
      check("a7_op1_0", a_op1_0, (s >= 18));
      check("a7_op2", a_op2, 0);
      check("a7_cur1", a_cur1, 0);
      check("a7_cur2", a_cur2, 0);
      step();
    end
    check("a7_wrap_slot", slot, 0);
    check("a7_wrap_cnt", sample_cnt, 2);

    // clk_en gating
    exp_slot = 0;
    for (int k = 0; k < 8; k++) begin
      clk_en = (k % 2 == 0);
      step();
      if (clk_en) exp_slot++;
      check("gate_slot", slot, exp_slot);
    end
    clk_en = 1'b1; step(15);
    check("gate_slot19", slot, 19);
    check("gate_fb19", fb_sel, 0);
    clk_en = 1'b0; step(3);
    check("gate_hold_slot", slot, 19);
    check("gate_hold_fb", fb_sel, 0);
    fsm_reset = 1'b1; step(); fsm_reset = 1'b0;
    check("gate_frst_ignored", slot, 19);

    // fsm_reset coinciding with the last slot
    clk_en = 1'b1; step(4);
    check("last_slot", slot, 23);
    check("last_sel", sel_last, 1);
    fsm_reset = 1'b1; step(); fsm_reset = 1'b0;
    check("last_frst_slot", slot, 0);
    check("last_frst_cnt", sample_cnt, 2);
    check("last_frst_fb", fb_sel, 0);

    // Asynchronous reset mid-sample
    step(11);
    check("arst_pre_slot", slot, 11);
    #2 reset_n = 1'b0;
    #1;
    check("arst_slot", slot, 0);
    check("arst_cnt", sample_cnt, 0);
    check("arst_fb", fb_sel, 1);
    step(); reset_n = 1'b1;

    // Algorithm change 0 -> 4 at slot 10
    connect = 3'd0;
    fsm_reset = 1'b1; step(); fsm_reset = 1'b0;
    check("alg0_op2_s0", a_op2, 1);
    check("alg0_cur2_s0", a_cur2, 0);
    step(10);
    connect = 3'd4;
    #1;
    check("alg_chg_s10_slot", slot, 10);
    check("alg_chg_s10_out", a_out, 0);
    check("alg_chg_s10_cur2", a_cur2, 1);
    step(8);
    check("alg_chg_s18_out", a_out, LATCHED ? 0 : 1);
    step(5);
    check("alg_chg_s23_out", a_out, LATCHED ? 0 : 1);
    step();
    check("alg4_s0_slot", slot, 0);
    check("alg4_s0_op2", a_op2, 0);
    check("alg4_s0_out", a_out, 1);
    step(18);
    check("alg4_s18_out", a_out, 1);

    // NUM_CH = 8 decodes over one full sample
    en8 = 1'b1;
    for (int s = 0; s < 32; s++) begin
      check("n8_slot", slot8, s);
      check("n8_op2_sel", op2_8, (s >= 24));
      check("n8_dac_load", dl_8, (s % 4 == 0));
      check("n8_dac_out_sel", dos_8, (s >= 16));
      check("n8_ch3_sel", ch3_8, (s % 8 == 2));
      check("n8_dac_ch6", dch6_8, (s >= 4 && s < 8));
      check("n8_sel_last", sl_8, (s == 31));
      step();
    end
    check("n8_wrap_slot", slot8, 0);
    check("n8_wrap_cnt", cnt8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
